// File: rtl/move_object_ctrl.sv
// move_object_ctrl
//   Owns the object's top-left position and steps it from the four direction
//   buttons once per move tick. After each tick the block waits SETTLE cycles
//   so the downstream colide_* stages can return flags for the current
//   position, then decides every axis in a single DECIDE cycle.
//
// Ports
//   VGA_clk        in   pixel clock, all logic on posedge
//   reset          in   asynchronous, active-high reset
//   btn_right/left/down/up  in  move requests (asynchronous, active high)
//   tamanho        in   object side length in pixels (7 bits)
//   colisao_max_x  in   +x move blocked
//   colisao_min_x  in   -x move blocked
//   colisao_max_y  in   +y move blocked
//   colisao_min_y  in   -y move blocked
//   xPos           out  object x position (10 bits, registered)
//   yPos           out  object y position (9 bits, registered)
//   moved          out  one-cycle pulse on the cycle the position changes
//   blocked        out  one-cycle pulse when a request was denied
module move_object_ctrl #(
  parameter int TICK_DIV = 250000,
  parameter int STEP     = 1,
  parameter int SETTLE   = 2,
  parameter int X_INIT   = 20,
  parameter int Y_INIT   = 20,
  parameter int X_MAX    = 640,
  parameter int Y_MAX    = 480
) (
  input  logic       VGA_clk,
  input  logic       reset,
  input  logic       btn_right,
  input  logic       btn_left,
  input  logic       btn_down,
  input  logic       btn_up,
  input  logic [6:0] tamanho,
  input  logic       colisao_max_x,
  input  logic       colisao_min_x,
  input  logic       colisao_max_y,
  input  logic       colisao_min_y,
  output logic [9:0] xPos,
  output logic [8:0] yPos,
  output logic       moved,
  output logic       blocked
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SET_W = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    WAIT_TICK,
    SETTLE_ST,
    DECIDE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [SET_W-1:0] settle_cnt;

  // Request bit order everywhere: {up, down, left, right}
  logic [3:0] btn_meta;
  logic [3:0] btn_sync;
  logic [3:0] req_lat;

  // Two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= {btn_up, btn_down, btn_left, btn_right};
      btn_sync <= btn_meta;
    end
  end

  // Free-running move tick divider, independent of the FSM state
  assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Decision logic: bound checks in 11 bits so neither sum nor compare wraps
  logic [10:0] x_ext, y_ext, right_sum, down_sum;
  logic        req_r, req_l, req_d, req_u;
  logic        right_ok, left_ok, down_ok, up_ok;
  logic        mv_r, mv_l, mv_d, mv_u;
  logic        blk_x, blk_y;
  logic [9:0]  next_x;
  logic [8:0]  next_y;

  assign {req_u, req_d, req_l, req_r} = req_lat;

  assign x_ext     = {1'b0, xPos};
  assign y_ext     = {2'b00, yPos};
  assign right_sum = x_ext + {4'b0000, tamanho} + 11'(STEP);
  assign down_sum  = y_ext + {4'b0000, tamanho} + 11'(STEP);

  assign right_ok = !colisao_max_x && (right_sum <= 11'(X_MAX));
  assign left_ok  = !colisao_min_x && (x_ext >= 11'(STEP));
  assign down_ok  = !colisao_max_y && (down_sum <= 11'(Y_MAX));
  assign up_ok    = !colisao_min_y && (y_ext >= 11'(STEP));

  // Opposite requests on one axis cancel each other and are not "blocked"
  assign mv_r = req_r && !req_l && right_ok;
  assign mv_l = req_l && !req_r && left_ok;
  assign mv_d = req_d && !req_u && down_ok;
  assign mv_u = req_u && !req_d && up_ok;

  assign blk_x = (req_r && !req_l && !right_ok) || (req_l && !req_r && !left_ok);
  assign blk_y = (req_d && !req_u && !down_ok) || (req_u && !req_d && !up_ok);

  assign next_x = mv_r ? (xPos + 10'(STEP)) : (mv_l ? (xPos - 10'(STEP)) : xPos);
  assign next_y = mv_d ? (yPos + 9'(STEP))  : (mv_u ? (yPos - 9'(STEP))  : yPos);

  // Move FSM: latch requests on tick, let the flags settle, then commit once
  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_TICK;
      settle_cnt <= '0;
      req_lat    <= '0;
      xPos       <= 10'(X_INIT);
      yPos       <= 9'(Y_INIT);
      moved      <= 1'b0;
      blocked    <= 1'b0;
    end else begin
      moved   <= 1'b0;
      blocked <= 1'b0;
      case (state)
        WAIT_TICK: begin
          if (tick) begin
            req_lat    <= btn_sync;
            settle_cnt <= '0;
            state      <= SETTLE_ST;
          end
        end
        SETTLE_ST: begin
          if (settle_cnt == SET_W'(SETTLE - 1)) begin
            state <= DECIDE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        DECIDE: begin
          xPos    <= next_x;
          yPos    <= next_y;
          moved   <= mv_r || mv_l || mv_d || mv_u;
          blocked <= blk_x || blk_y;
          state   <= WAIT_TICK;
        end
        default: begin
          state <= WAIT_TICK;
        end
      endcase
    end
  end

endmodule
